// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode, and mux-select encodings for the multicycle core
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } ctrlStateT;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instrClassT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;
  localparam logic [1:0] PC_JAL    = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  // Classes whose second ALU operand is the immediate rather than rs2.
  function automatic logic usesImm(input instrClassT cls);
    return (cls == CLS_IALU) || (cls == CLS_LOAD) || (cls == CLS_STORE) || (cls == CLS_JALR);
  endfunction

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// rtl/control_unit_opcode_decoder.sv - combinational opcode to instruction-class decode
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output instrClassT instrClass
);

  always_comb begin
    instrClass = CLS_ILLEGAL;
    case (opcode)
      OP_R:      instrClass = CLS_R;
      OP_IALU:   instrClass = CLS_IALU;
      OP_LOAD:   instrClass = CLS_LOAD;
      OP_STORE:  instrClass = CLS_STORE;
      OP_BRANCH: instrClass = CLS_BRANCH;
      OP_JAL:    instrClass = CLS_JAL;
      OP_JALR:   instrClass = CLS_JALR;
      OP_LUI:    instrClass = CLS_LUI;
      OP_SYSTEM: instrClass = CLS_SYSTEM;
      default:   instrClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle control FSM with load wait counter and retire counter
module control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int DWIDTH   = 32
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] irOut,
  input  logic              comparatorOut,
  output logic              pcEn,
  output logic [1:0]        pcSelect,
  output logic              regWrite,
  output logic              aluSrc,
  output logic              ramRdEn,
  output logic              ramWrEn,
  output logic              isByte,
  output logic              isHalf,
  output logic              isWord,
  output logic [1:0]        memToReg,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic [DWIDTH-1:0] instret
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  ctrlStateT   curState;
  ctrlStateT   nextState;
  logic [6:0]  opcodeReg;
  logic [2:0]  funct3Reg;
  logic [2:0]  waitCnt;
  logic [6:0]  decOpcode;
  logic [1:0]  sizeSel;
  instrClassT  instrClass;
  logic        unusedIr;

  assign unusedIr = ^{irOut[DWIDTH-1:15], irOut[11:7], funct3Reg[2]};

  // DECODE classifies the live instruction word; later states use the latched copy.
  assign decOpcode = (curState == DECODE) ? irOut[6:0]   : opcodeReg;
  assign sizeSel   = (curState == DECODE) ? irOut[13:12] : funct3Reg[1:0];

  opcode_decoder uDecoder (
    .opcode    (decOpcode),
    .instrClass(instrClass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      curState  <= FETCH;
      opcodeReg <= '0;
      funct3Reg <= '0;
      waitCnt   <= '0;
      instret   <= '0;
    end else begin
      curState <= nextState;
      if (curState == DECODE) begin
        opcodeReg <= irOut[6:0];
        funct3Reg <= irOut[14:12];
      end
      if (curState == EXEC && nextState == MEM) begin
        waitCnt <= WAIT_INIT;
      end else if (curState == MEM && waitCnt != 3'd0) begin
        waitCnt <= waitCnt - 3'd1;
      end
      if (pcEn) begin
        instret <= instret + {{(DWIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    nextState = curState;
    pcEn      = 1'b0;
    pcSelect  = PC_PLUS4;
    regWrite  = 1'b0;
    aluSrc    = 1'b0;
    ramRdEn   = 1'b0;
    ramWrEn   = 1'b0;
    isByte    = 1'b0;
    isHalf    = 1'b0;
    isWord    = 1'b0;
    memToReg  = WB_ALU;
    case (curState)
      FETCH: nextState = DECODE;
      DECODE: begin
        case (instrClass)
          CLS_SYSTEM:  nextState = HALT;
          CLS_ILLEGAL: nextState = TRAP;
          CLS_LOAD, CLS_STORE: nextState = (sizeSel == SIZE_BAD) ? TRAP : EXEC;
          default:     nextState = EXEC;
        endcase
      end
      EXEC: begin
        aluSrc = usesImm(instrClass);
        case (instrClass)
          CLS_LOAD, CLS_STORE: nextState = MEM;
          CLS_BRANCH: begin
            pcEn      = 1'b1;
            pcSelect  = comparatorOut ? PC_BRANCH : PC_PLUS4;
            nextState = FETCH;
          end
          default: nextState = WB;
        endcase
      end
      MEM: begin
        isByte = (sizeSel == SIZE_BYTE);
        isHalf = (sizeSel == SIZE_HALF);
        isWord = (sizeSel == SIZE_WORD);
        if (instrClass == CLS_STORE) begin
          ramWrEn   = 1'b1;
          pcEn      = 1'b1;
          nextState = FETCH;
        end else begin
          ramRdEn = 1'b1;
          if (waitCnt == 3'd0) nextState = WB;
        end
      end
      WB: begin
        regWrite  = 1'b1;
        pcEn      = 1'b1;
        nextState = FETCH;
        case (instrClass)
          CLS_LOAD: memToReg = WB_MEM;
          CLS_JAL: begin
            memToReg = WB_LINK;
            pcSelect = PC_JAL;
          end
          CLS_JALR: begin
            memToReg = WB_LINK;
            pcSelect = PC_JALR;
          end
          CLS_LUI: memToReg = WB_IMM;
          default: memToReg = WB_ALU;
        endcase
      end
      HALT, TRAP: nextState = curState;
      default: nextState = FETCH;
    endcase
  end

  assign state   = curState;
  assign halted  = (curState == HALT);
  assign illegal = (curState == TRAP);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench comparing per-cycle control outputs to a reference trace
module tb_control_unit;

  localparam int MEM_WAIT = 2;
  localparam int DWIDTH   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DWIDTH-1:0] irOut;
  logic              comparatorOut;
  logic              pcEn, regWrite, aluSrc, ramRdEn, ramWrEn;
  logic              isByte, isHalf, isWord, halted, illegal;
  logic [1:0]        pcSelect, memToReg;
  logic [2:0]        state;
  logic [DWIDTH-1:0] instret;

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT(MEM_WAIT), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .reset(reset), .irOut(irOut), .comparatorOut(comparatorOut),
    .pcEn(pcEn), .pcSelect(pcSelect), .regWrite(regWrite), .aluSrc(aluSrc),
    .ramRdEn(ramRdEn), .ramWrEn(ramWrEn), .isByte(isByte), .isHalf(isHalf),
    .isWord(isWord), .memToReg(memToReg), .state(state), .halted(halted),
    .illegal(illegal), .instret(instret)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcEn;
    logic [1:0] pcSel;
    logic       regWrite;
    logic       aluSrc;
    logic       rdEn;
    logic       wrEn;
    logic [2:0] size;
    logic [1:0] m2r;
    logic       halted;
    logic       illegal;
  } obsT;

  typedef struct {
    obsT   o;
    string tag;
  } expT;

  expT               sbq[$];
  int                compared   = 0;
  int                mismatched = 0;
  logic [DWIDTH-1:0] expInstret;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obsT sample();
    obsT o;
    o.st = state; o.pcEn = pcEn; o.pcSel = pcSelect; o.regWrite = regWrite;
    o.aluSrc = aluSrc; o.rdEn = ramRdEn; o.wrEn = ramWrEn;
    o.size = {isByte, isHalf, isWord}; o.m2r = memToReg;
    o.halted = halted; o.illegal = illegal;
    return o;
  endfunction

  task automatic push(input string tag, input obsT o);
    expT e;
    e.o = o;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // Reference cycle trace of one instruction, built from the opcode/funct3 fields.
  task automatic expectInstr(input string name, input logic [31:0] ir, input logic cmp, output bit retired);
    obsT        o;
    logic [6:0] op;
    logic [1:0] sz;
    bit isLoad, isStore, isBranch, isSys, isWbOnly;
    op = ir[6:0];
    sz = ir[13:12];
    isLoad   = (op == 7'b0000011);
    isStore  = (op == 7'b0100011);
    isBranch = (op == 7'b1100011);
    isSys    = (op == 7'b1110011);
    isWbOnly = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b1101111) ||
               (op == 7'b1100111) || (op == 7'b0110111);
    retired = 1'b0;
    o = '0;            push({name, "/fetch"}, o);
    o.st = 3'd1;       push({name, "/decode"}, o);
    if (isSys) begin
      o = '0; o.st = 3'd5; o.halted = 1'b1;
      for (int i = 0; i < 20; i++) push($sformatf("%s/halt%0d", name, i), o);
    end else if (!(isLoad || isStore || isBranch || isWbOnly) || ((isLoad || isStore) && sz == 2'b11)) begin
      o = '0; o.st = 3'd6; o.illegal = 1'b1;
      for (int i = 0; i < 20; i++) push($sformatf("%s/trap%0d", name, i), o);
    end else begin
      retired = 1'b1;
      o = '0; o.st = 3'd2;
      o.aluSrc = isLoad || isStore || (op == 7'b0010011) || (op == 7'b1100111);
      if (isBranch) begin
        o.pcEn = 1'b1;
        o.pcSel = cmp ? 2'b01 : 2'b00;
      end
      push({name, "/exec"}, o);
      o = '0; o.st = 3'd3;
      o.size = (sz == 2'b00) ? 3'b100 : (sz == 2'b01) ? 3'b010 : 3'b001;
      if (isStore) begin
        o.wrEn = 1'b1; o.pcEn = 1'b1;
        push({name, "/mem"}, o);
      end else if (isLoad) begin
        o.rdEn = 1'b1;
        for (int i = 0; i <= MEM_WAIT; i++) push($sformatf("%s/mem%0d", name, i), o);
      end
      if (isLoad || isWbOnly) begin
        o = '0; o.st = 3'd4; o.regWrite = 1'b1; o.pcEn = 1'b1;
        if (isLoad) o.m2r = 2'b01;
        if (op == 7'b1101111) begin o.m2r = 2'b10; o.pcSel = 2'b11; end
        if (op == 7'b1100111) begin o.m2r = 2'b10; o.pcSel = 2'b10; end
        if (op == 7'b0110111) o.m2r = 2'b11;
        push({name, "/wb"}, o);
      end
    end
  endtask

  task automatic runInstr(input string name, input logic [31:0] ir, input logic cmp);
    bit  retired;
    expT e;
    irOut = ir;
    comparatorOut = cmp;
    expectInstr(name, ir, cmp, retired);
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      checkEq(e.tag, 32'(sample()), 32'(e.o));
    end
    if (retired) expInstret = expInstret + 1'b1;
    @(posedge clk);
    #1;
    checkEq({name, "/instret"}, instret, expInstret);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expInstret = '0;
    checkEq({tag, "/outputs"}, 32'(sample()), 32'd0);
    checkEq({tag, "/instret"}, instret, 32'd0);
  endtask

  initial begin
    expT e;
    bit  retired;
    reset = 1'b1;
    irOut = '0;
    comparatorOut = 1'b0;
    expInstret = '0;
    repeat (2) @(posedge clk);
    doReset("reset0");

    runInstr("add",   32'h002081B3, 1'b0);
    runInstr("lw",    32'h0000A183, 1'b0);
    runInstr("beqT",  32'h00208463, 1'b1);
    runInstr("beqN",  32'h00208463, 1'b0);
    runInstr("sb",    32'h00208023, 1'b0);
    runInstr("addi",  32'h00108093, 1'b0);
    runInstr("jal",   32'h008000EF, 1'b0);
    runInstr("jalr",  32'h000080E7, 1'b0);
    runInstr("lui",   32'h123450B7, 1'b0);
    runInstr("lh",    32'h00109183, 1'b0);
    runInstr("lbu",   32'h0000C183, 1'b0);
    runInstr("sw",    32'h0020A023, 1'b1);
    runInstr("addX0", 32'h00208033, 1'b0);

    runInstr("auipc", 32'h00000017, 1'b0);
    doReset("resetTrap");
    runInstr("ldBad", 32'h0000B183, 1'b0);
    doReset("resetBad");
    runInstr("ecall", 32'h00000073, 1'b0);
    doReset("resetHalt");

    // Reset lands in the second load-wait cycle; nothing may be written back.
    irOut = 32'h0000A183;
    expectInstr("lwRst", 32'h0000A183, 1'b0, retired);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      checkEq(e.tag, 32'(sample()), 32'(e.o));
    end
    reset = 1'b1;
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkEq($sformatf("lwRst/state%0d", i), 32'(state), 32'd0);
      checkEq($sformatf("lwRst/regWrite%0d", i), 32'(regWrite), 32'd0);
    end
    checkEq("lwRst/instret", instret, 32'd0);
    reset = 1'b0;
    expInstret = '0;
    runInstr("addAfter", 32'h002081B3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
